// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, types and helpers for the bus trace formatter
package trace_pkg;

   // Trace entry layout: {SYNC, RW, extDB, extAB}
   localparam int TRACE_W  = 26;
   localparam int AB_LSB   = 0;
   localparam int DB_LSB   = 16;
   localparam int RW_BIT   = 24;
   localparam int SYNC_BIT = 25;

   localparam int LINE_LEN = 11;
   localparam int IDX_W    = 4;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_R     = 8'h52;
   localparam logic [7:0] ASCII_W     = 8'h57;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_CLR_W,
      ST_SEND,
      ST_WAIT
   } fsm_state_t;

   function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with combinational head read data
module trace_fifo #(
   parameter int WIDTH      = 26,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_L,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign dout = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bus_trace_formatter.sv
// rtl/bus_trace_formatter.sv - captures CPU bus cycles on phi1 and prints one ASCII line each to the LCD
module bus_trace_formatter
   import trace_pkg::*;
#(
   parameter int DEPTH_LOG2  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_L,
   input  logic                  phi1,
   input  logic                  capture_en,
   input  logic [15:0]           extAB,
   input  logic [7:0]            extDB,
   input  logic                  RW,
   input  logic                  SYNC,
   input  logic                  ovf_clr,
   input  logic                  initDone,
   input  logic                  writeDone,
   output logic                  writeStart,
   output logic [7:0]            dataIn,
   output logic                  clearAll,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   fifo_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_q;
   logic                   sync_q_d;
   logic                   phi1_rise;
   logic                   push_req;
   logic [TRACE_W-1:0]     push_entry;

   logic [TRACE_W-1:0]     fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic                   drop;

   fsm_state_t             state;
   fsm_state_t             state_nxt;
   logic                   idx_inc;
   logic [IDX_W-1:0]       char_idx;
   logic [TRACE_W-1:0]     line_q;
   logic [15:0]            line_ab;
   logic [7:0]             line_db;
   logic [7:0]             line_char;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         sync_chain <= '0;
         sync_q_d   <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], phi1};
         sync_q_d   <= sync_q;
      end
   end

   assign sync_q     = sync_chain[SYNC_STAGES-1];
   assign phi1_rise  = sync_q & ~sync_q_d;
   assign push_req   = phi1_rise & capture_en;
   assign push_entry = {SYNC, RW, extDB, extAB};

   trace_fifo #(
      .WIDTH      (TRACE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .rst_L (rst_L),
      .push  (push_req),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A drop wins over a simultaneous clear so no lost entry goes unreported.
   assign drop = push_req & fifo_full & ~fifo_pop;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      fifo_pop   = 1'b0;
      idx_inc    = 1'b0;
      writeStart = 1'b0;
      clearAll   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (initDone && !fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_CLR;
            end
         end
         ST_CLR: begin
            clearAll  = 1'b1;
            state_nxt = ST_CLR_W;
         end
         ST_CLR_W: begin
            if (writeDone) begin
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            writeStart = 1'b1;
            state_nxt  = ST_WAIT;
         end
         ST_WAIT: begin
            if (writeDone) begin
               if (char_idx == LAST_IDX) begin
                  state_nxt = ST_IDLE;
               end else begin
                  idx_inc   = 1'b1;
                  state_nxt = ST_SEND;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         line_q   <= '0;
         char_idx <= '0;
      end else if (fifo_pop) begin
         line_q   <= fifo_dout;
         char_idx <= '0;
      end else if (idx_inc) begin
         char_idx <= char_idx + 1'b1;
      end
   end

   assign line_ab = line_q[AB_LSB +: 16];
   assign line_db = line_q[DB_LSB +: 8];

   always_comb begin
      line_char = ASCII_SPACE;
      case (char_idx)
         4'd0:    line_char = hex2ascii(line_ab[15:12]);
         4'd1:    line_char = hex2ascii(line_ab[11:8]);
         4'd2:    line_char = hex2ascii(line_ab[7:4]);
         4'd3:    line_char = hex2ascii(line_ab[3:0]);
         4'd5:    line_char = hex2ascii(line_db[7:4]);
         4'd6:    line_char = hex2ascii(line_db[3:0]);
         4'd8:    line_char = line_q[RW_BIT] ? ASCII_R : ASCII_W;
         4'd10:   line_char = line_q[SYNC_BIT] ? ASCII_STAR : ASCII_DOT;
         default: line_char = ASCII_SPACE;
      endcase
   end

   // Character stays on the bus from the request until the LCD acknowledges it.
   assign dataIn = ((state == ST_SEND) || (state == ST_WAIT)) ? line_char : ASCII_SPACE;

endmodule

// File: tb/tb_bus_trace_formatter.sv
// tb/tb_bus_trace_formatter.sv - randomized self-checking bench for bus_trace_formatter
module tb_bus_trace_formatter;

   localparam int DEPTH    = 16;
   localparam int LINE_LEN = 11;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        phi1;
   logic        capture_en;
   logic [15:0] extAB;
   logic [7:0]  extDB;
   logic        RW;
   logic        SYNC;
   logic        ovf_clr;
   logic        initDone;
   logic        writeDone;
   logic        writeStart;
   logic [7:0]  dataIn;
   logic        clearAll;
   logic        overflow;
   logic [4:0]  fifo_count;

   int vectors     = 0;
   int miscompares = 0;

   logic [25:0] exp_q [$];
   logic [7:0]  rx_q  [$];
   int          n_clears = 0;
   int          n_ws     = 0;
   logic        lcd_stall = 1'b0;
   bit          pending   = 1'b0;
   int          delay     = 0;

   bus_trace_formatter #(
      .DEPTH_LOG2  (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst_L      (rst_L),
      .phi1       (phi1),
      .capture_en (capture_en),
      .extAB      (extAB),
      .extDB      (extDB),
      .RW         (RW),
      .SYNC       (SYNC),
      .ovf_clr    (ovf_clr),
      .initDone   (initDone),
      .writeDone  (writeDone),
      .writeStart (writeStart),
      .dataIn     (dataIn),
      .clearAll   (clearAll),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // LCD model: records each request and acknowledges it three clocks later unless stalled
   initial begin
      writeDone = 1'b0;
      forever begin
         @(negedge clk);
         writeDone = 1'b0;
         if (pending) begin
            if (!lcd_stall) begin
               if (delay <= 1) begin
                  writeDone = 1'b1;
                  pending   = 1'b0;
               end else begin
                  delay--;
               end
            end
         end else if (writeStart || clearAll) begin
            if (writeStart) begin
               rx_q.push_back(dataIn);
               n_ws++;
            end
            if (clearAll) begin
               n_clears++;
            end
            pending = 1'b1;
            delay   = 3;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_char(input logic [25:0] e, input int i);
      string      hx;
      logic [7:0] line [LINE_LEN];
      hx      = "0123456789ABCDEF";
      line[0] = hx[e[15:12]];
      line[1] = hx[e[11:8]];
      line[2] = hx[e[7:4]];
      line[3] = hx[e[3:0]];
      line[4] = " ";
      line[5] = hx[e[23:20]];
      line[6] = hx[e[19:16]];
      line[7] = " ";
      line[8] = e[24] ? "R" : "W";
      line[9] = " ";
      line[10] = e[25] ? "*" : ".";
      return line[i];
   endfunction

   task automatic pulse(input logic [15:0] ab, input logic [7:0] db, input logic rw, input logic sy);
      @(negedge clk);
      extAB = ab;
      extDB = db;
      RW    = rw;
      SYNC  = sy;
      phi1  = 1'b1;
      if (capture_en && exp_q.size() < DEPTH) begin
         exp_q.push_back({sy, rw, db, ab});
      end
      repeat (5) @(negedge clk);
      phi1 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic rand_pulse();
      pulse(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic check_line(input string tag);
      logic [25:0] e;
      int          t;
      t = 0;
      while (rx_q.size() < LINE_LEN && t < 600) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_len"}, 32'(rx_q.size()), 32'(LINE_LEN));
      if (rx_q.size() >= LINE_LEN && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int i = 0; i < LINE_LEN; i++) begin
            chk($sformatf("%s_c%0d", tag, i), 32'(rx_q.pop_front()), 32'(exp_char(e, i)));
         end
      end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      logic [7:0] c0de_line [LINE_LEN];
      logic [7:0] held;
      int         base_ws;
      int         base_clr;
      int         k;
      int         t;

      c0de_line = '{8'h43, 8'h30, 8'h44, 8'h45, 8'h20, 8'h35, 8'h41, 8'h20, 8'h52, 8'h20, 8'h2A};

      rst_L      = 1'b0;
      phi1       = 1'b0;
      capture_en = 1'b0;
      extAB      = '0;
      extDB      = '0;
      RW         = 1'b0;
      SYNC       = 1'b0;
      ovf_clr    = 1'b0;
      initDone   = 1'b0;

      // Reset held while phi1 toggles
      for (int i = 0; i < 6; i++) begin
         repeat (3) @(negedge clk);
         phi1 = ~phi1;
      end
      phi1 = 1'b0;
      @(negedge clk);
      chk("rst_writeStart", 32'(writeStart), 32'd0);
      chk("rst_clearAll",   32'(clearAll),   32'd0);
      chk("rst_dataIn",     32'(dataIn),     32'h20);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      rst_L      = 1'b1;
      capture_en = 1'b1;
      repeat (3) @(negedge clk);

      // Directed C0DE entry with capture latency of three clocks
      @(negedge clk);
      extAB = 16'hC0DE;
      extDB = 8'h5A;
      RW    = 1'b1;
      SYNC  = 1'b1;
      phi1  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("lat_before", 32'(fifo_count), 32'd0);
      @(negedge clk);
      chk("lat_after", 32'(fifo_count), 32'd1);
      repeat (3) @(negedge clk);
      phi1 = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_ws_before_init",  32'(n_ws),     32'd0);
      chk("no_clr_before_init", 32'(n_clears), 32'd0);
      initDone = 1'b1;
      t = 0;
      while (rx_q.size() < LINE_LEN && t < 600) begin
         @(negedge clk);
         t++;
      end
      chk("c0de_len", 32'(rx_q.size()), 32'(LINE_LEN));
      if (rx_q.size() >= LINE_LEN) begin
         for (int i = 0; i < LINE_LEN; i++) begin
            chk($sformatf("c0de_c%0d", i), 32'(rx_q.pop_front()), 32'(c0de_line[i]));
         end
      end
      chk("c0de_clears", 32'(n_clears), 32'd1);
      repeat (8) @(negedge clk);

      // LCD stalls mid-line while capture keeps filling the FIFO
      rand_pulse();
      t = 0;
      while (rx_q.size() < 3 && t < 600) begin
         @(negedge clk);
         t++;
      end
      lcd_stall = 1'b1;
      held      = dataIn;
      base_ws   = n_ws;
      for (int i = 0; i < 3; i++) begin
         rand_pulse();
         chk($sformatf("stall_dataIn_%0d", i), 32'(dataIn), 32'(held));
      end
      chk("stall_no_ws",  32'(n_ws),       32'(base_ws));
      chk("stall_count",  32'(fifo_count), 32'd3);
      chk("stall_char2",  32'(held),       32'(exp_char(exp_q[0], 2)));
      lcd_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_line($sformatf("stall_line%0d", i));
      end

      // Overflow: 17 captures with the LCD not draining
      initDone = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rand_pulse();
      end
      chk("ovf_count",    32'(fifo_count), 32'd16);
      chk("ovf_flag",     32'(overflow),   32'd1);
      initDone = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_line($sformatf("ovf_line%0d", i));
      end
      chk("ovf_sticky",   32'(overflow),   32'd1);
      chk("ovf_drained",  32'(fifo_count), 32'd0);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared",  32'(overflow),   32'd0);

      // Capture disabled
      capture_en = 1'b0;
      base_ws    = n_ws;
      base_clr   = n_clears;
      for (int i = 0; i < 5; i++) begin
         rand_pulse();
      end
      repeat (20) @(negedge clk);
      chk("cap_off_count", 32'(fifo_count), 32'd0);
      chk("cap_off_ws",    32'(n_ws),       32'(base_ws));
      chk("cap_off_clr",   32'(n_clears),   32'(base_clr));
      capture_en = 1'b1;

      // Push and pop in the same cycle at full, then reset mid-SEND
      initDone = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rand_pulse();
      end
      chk("pp_full", 32'(fifo_count), 32'd16);
      @(negedge clk);
      extAB = 16'($urandom);
      extDB = 8'($urandom);
      phi1  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      initDone = 1'b1;
      @(negedge clk);
      chk("pp_count", 32'(fifo_count), 32'd16);
      chk("pp_ovf",   32'(overflow),   32'd0);
      repeat (3) @(negedge clk);
      phi1 = 1'b0;
      k = 0;
      t = 0;
      while (k < 5 && t < 600) begin
         @(negedge clk);
         if (writeStart) begin
            k++;
         end
         t++;
      end
      chk("midsend_reached", 32'(k), 32'd5);
      rst_L = 1'b0;
      #1;
      chk("midrst_writeStart", 32'(writeStart), 32'd0);
      chk("midrst_clearAll",   32'(clearAll),   32'd0);
      chk("midrst_dataIn",     32'(dataIn),     32'h20);
      chk("midrst_count",      32'(fifo_count), 32'd0);
      @(negedge clk);
      rst_L = 1'b1;
      exp_q.delete();
      rx_q.delete();
      base_ws  = n_ws;
      base_clr = n_clears;
      repeat (30) @(negedge clk);
      chk("post_rst_ws",    32'(n_ws),       32'(base_ws));
      chk("post_rst_clr",   32'(n_clears),   32'(base_clr));
      chk("post_rst_count", 32'(fifo_count), 32'd0);
      rand_pulse();
      check_line("post_rst_line");
      chk("post_rst_clr1",  32'(n_clears),   32'(base_clr + 1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
